// File: rtl/laser_link_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | laser_link_pkg                                                     |
// | Shared types and encodings for the laser link scheduler: FSM state |
// | enum, byte tags for header/ACK bytes and the byte builder.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package laser_link_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FILL      = 3'd1,
    SEND_HDR  = 3'd2,
    SEND_DATA = 3'd3,
    WAIT_ACK  = 3'd4,
    SEND_ACK  = 3'd5,
    ERROR     = 3'd6
  } state_t;

  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam logic [3:0] ACK_TAG = 4'h5;

  // Header and ACK bytes share the same layout: tag nibble, sequence nibble.
  function automatic logic [7:0] link_byte(input logic [3:0] tag, input logic [3:0] seq);
    return {tag, seq};
  endfunction

endpackage
`default_nettype wire

// File: rtl/laser_link_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | laser_link_if                                                      |
// | Bundles the host byte source, transmitter, receiver, ACK request   |
// | and status signals of the laser link scheduler.                    |
// |   slave  : the scheduler side                                      |
// |   master : the environment (host, transmitter, receiver)           |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface laser_link_if;
  logic       link_en;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic [7:0] tx_data;
  logic       tx_data_ready;
  logic       tx_en;
  logic       tx_done;
  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       ack_req;
  logic [3:0] ack_seq;
  logic       ack_grant;
  logic [3:0] seq_num;
  logic       frame_sent;
  logic       link_err;
  logic       err_clear;

  modport slave (
    input  link_en, src_valid, src_data, tx_done, rx_valid, rx_byte,
           ack_req, ack_seq, err_clear,
    output src_ready, tx_data, tx_data_ready, tx_en, ack_grant, seq_num,
           frame_sent, link_err
  );

  modport master (
    output link_en, src_valid, src_data, tx_done, rx_valid, rx_byte,
           ack_req, ack_seq, err_clear,
    input  src_ready, tx_data, tx_data_ready, tx_en, ack_grant, seq_num,
           frame_sent, link_err
  );
endinterface
`default_nettype wire

// File: rtl/laser_link_scheduler_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | laser_frame_buffer                                                 |
// | One-frame payload store: PKT_BYTES x 8 register file written in    |
// | order at the fill count, read by index.                            |
// | Ports: clock_base, reset (async, active-high)                      |
// |   wr_en_i/wr_data_i : append a byte (ignored when full)            |
// |   clr_i             : empty the buffer                             |
// |   rd_idx_i/rd_data_o: combinational read port                      |
// |   count_o/full_o    : fill level                                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module laser_frame_buffer #(
  parameter  int PKT_BYTES = 4,
  localparam int IDXW      = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1,
  localparam int CNTW      = $clog2(PKT_BYTES + 1)
) (
  input  wire logic            clock_base,
  input  wire logic            reset,
  input  wire logic            wr_en_i,
  input  wire logic [7:0]      wr_data_i,
  input  wire logic            clr_i,
  input  wire logic [IDXW-1:0] rd_idx_i,
  output logic      [7:0]      rd_data_o,
  output logic      [CNTW-1:0] count_o,
  output logic                 full_o
);

  logic [7:0]      mem_q [PKT_BYTES];
  logic [CNTW-1:0] count_q;

  assign full_o  = (count_q == CNTW'(PKT_BYTES));
  assign count_o = count_q;

  always_ff @(posedge clock_base or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < PKT_BYTES; i++) mem_q[i] <= 8'h00;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (wr_en_i && !full_o) begin
      count_q <= count_q + CNTW'(1);
      for (int i = 0; i < PKT_BYTES; i++) begin
        if (count_q == CNTW'(i)) mem_q[i] <= wr_data_i;
      end
    end
  end

  always_comb begin
    rd_data_o = 8'h00;
    for (int i = 0; i < PKT_BYTES; i++) begin
      if (rd_idx_i == IDXW'(i)) rd_data_o = mem_q[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/laser_link_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | laser_link_scheduler                                               |
// | Shares one laser transmitter between outgoing data frames          |
// | (header {A,seq} + PKT_BYTES payload) and receive-side ACK bytes    |
// | ({5,seq}). Waits for a matching ACK, retransmits on timeout up to  |
// | MAX_RETRY times, then raises a sticky link error.                  |
// | Ports: clock_base, reset (async, active-high), link (slave modport)|
// |   optional: retx_total_o, ack_sent_total_o (saturating counters)   |
// | Optional feature macro: LASER_LINK_STATS_EN                        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module laser_link_scheduler
  import laser_link_pkg::*;
#(
  parameter int PKT_BYTES      = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MAX_RETRY      = 3
) (
  input  wire logic   clock_base,
  input  wire logic   reset,
  laser_link_if.slave link
`ifdef LASER_LINK_STATS_EN
  ,
  output logic [15:0] retx_total_o,
  output logic [15:0] ack_sent_total_o
`endif
);

  localparam int IDXW = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam int CNTW = $clog2(PKT_BYTES + 1);
  localparam int RW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t          state_q;
  logic            ret_wait_q;     // SEND_ACK detour started from WAIT_ACK
  logic            pend_q;         // byte handed to transmitter, awaiting tx_done
  logic            ack_latched_q;  // matching ACK seen during the detour
  logic [IDXW-1:0] idx_q;
  logic [15:0]     timer_q;
  logic [RW-1:0]   retry_q;
  logic [3:0]      seq_q;
  logic [7:0]      tx_data_q;
  logic            tx_data_ready_q;
  logic            ack_grant_q;
  logic            frame_sent_q;
  logic            link_err_q;

  logic            w_full;
  logic [CNTW-1:0] w_count;
  logic [7:0]      w_rd_data;
  logic            w_src_ready;
  logic            w_buf_wr;
  logic            w_rx_ack;
  logic            w_match;
  logic            w_buf_clr;
  logic            w_timeout;
  logic            w_last;
  logic            w_retx_evt;
  logic            w_grant_evt;

  // ACK requests take the channel away from FILL before a byte is taken.
  assign w_src_ready = (state_q == FILL) && !w_full && !link.ack_req;
  assign w_buf_wr    = w_src_ready && link.src_valid;
  assign w_rx_ack    = link.rx_valid && (link.rx_byte[7:4] == ACK_TAG) &&
                       (link.rx_byte[3:0] == seq_q);
  assign w_match     = w_rx_ack || ack_latched_q;
  assign w_buf_clr   = (state_q == WAIT_ACK) && w_match;
  assign w_timeout   = (timer_q == 16'(TIMEOUT_CYCLES - 1));
  assign w_last      = (idx_q == IDXW'(PKT_BYTES - 1));
  assign w_retx_evt  = (state_q == WAIT_ACK) && !w_match && !link.ack_req &&
                       w_timeout && (retry_q < RW'(MAX_RETRY));
  assign w_grant_evt = (state_q == SEND_ACK) && link.link_en && pend_q && link.tx_done;

  assign link.src_ready     = w_src_ready;
  assign link.tx_data       = tx_data_q;
  assign link.tx_data_ready = tx_data_ready_q;
  assign link.tx_en         = link.link_en;
  assign link.ack_grant     = ack_grant_q;
  assign link.seq_num       = seq_q;
  assign link.frame_sent    = frame_sent_q;
  assign link.link_err      = link_err_q;

  laser_frame_buffer #(
    .PKT_BYTES (PKT_BYTES)
  ) u_buffer (
    .clock_base (clock_base),
    .reset      (reset),
    .wr_en_i    (w_buf_wr),
    .wr_data_i  (link.src_data),
    .clr_i      (w_buf_clr),
    .rd_idx_i   (idx_q),
    .rd_data_o  (w_rd_data),
    .count_o    (w_count),
    .full_o     (w_full)
  );

  always_ff @(posedge clock_base or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      ret_wait_q      <= 1'b0;
      pend_q          <= 1'b0;
      ack_latched_q   <= 1'b0;
      idx_q           <= '0;
      timer_q         <= 16'd0;
      retry_q         <= '0;
      seq_q           <= 4'd0;
      tx_data_q       <= 8'h00;
      tx_data_ready_q <= 1'b0;
      ack_grant_q     <= 1'b0;
      frame_sent_q    <= 1'b0;
      link_err_q      <= 1'b0;
    end else begin
      tx_data_ready_q <= 1'b0;
      ack_grant_q     <= 1'b0;
      frame_sent_q    <= 1'b0;

      case (state_q)
        IDLE: begin
          pend_q <= 1'b0;
          if (link.ack_req) begin
            ret_wait_q <= 1'b0;
            state_q    <= SEND_ACK;
          end else if (w_full && link.link_en) begin
            state_q <= SEND_HDR;
          end else if (!w_full) begin
            state_q <= FILL;
          end
        end

        FILL: begin
          if (link.ack_req || w_full ||
              (w_buf_wr && (w_count == CNTW'(PKT_BYTES - 1)))) begin
            state_q <= IDLE;
          end
        end

        SEND_HDR: begin
          if (!link.link_en) begin
            pend_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!pend_q) begin
            tx_data_q       <= link_byte(HDR_TAG, seq_q);
            tx_data_ready_q <= 1'b1;
            pend_q          <= 1'b1;
          end else if (link.tx_done) begin
            pend_q  <= 1'b0;
            idx_q   <= '0;
            state_q <= SEND_DATA;
          end
        end

        SEND_DATA: begin
          if (!link.link_en) begin
            pend_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!pend_q) begin
            tx_data_q       <= w_rd_data;
            tx_data_ready_q <= 1'b1;
            pend_q          <= 1'b1;
          end else if (link.tx_done) begin
            pend_q <= 1'b0;
            if (w_last) begin
              timer_q       <= 16'd0;
              ack_latched_q <= 1'b0;
              state_q       <= WAIT_ACK;
            end else begin
              idx_q <= idx_q + IDXW'(1);
            end
          end
        end

        WAIT_ACK: begin
          if (w_match) begin
            frame_sent_q  <= 1'b1;
            seq_q         <= seq_q + 4'd1;
            retry_q       <= '0;
            ack_latched_q <= 1'b0;
            state_q       <= IDLE;
          end else if (link.ack_req) begin
            // Timer holds its value across the detour.
            ret_wait_q <= 1'b1;
            pend_q     <= 1'b0;
            state_q    <= SEND_ACK;
          end else if (w_timeout) begin
            pend_q <= 1'b0;
            if (w_retx_evt) begin
              retry_q <= retry_q + RW'(1);
              state_q <= SEND_HDR;
            end else begin
              link_err_q <= 1'b1;
              state_q    <= ERROR;
            end
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end

        SEND_ACK: begin
          if (ret_wait_q && w_rx_ack) ack_latched_q <= 1'b1;
          if (!link.link_en) begin
            pend_q  <= 1'b0;
            state_q <= IDLE;
          end else if (!pend_q) begin
            tx_data_q       <= link_byte(ACK_TAG, link.ack_seq);
            tx_data_ready_q <= 1'b1;
            pend_q          <= 1'b1;
          end else if (link.tx_done) begin
            pend_q      <= 1'b0;
            ack_grant_q <= 1'b1;
            state_q     <= ret_wait_q ? WAIT_ACK : IDLE;
          end
        end

        ERROR: begin
          if (link.err_clear) begin
            link_err_q <= 1'b0;
            retry_q    <= '0;
            state_q    <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LASER_LINK_STATS_EN
  logic [15:0] retx_total_q;
  logic [15:0] ack_sent_total_q;

  always_ff @(posedge clock_base or posedge reset) begin
    if (reset) begin
      retx_total_q     <= 16'd0;
      ack_sent_total_q <= 16'd0;
    end else begin
      if (w_retx_evt && (retx_total_q != 16'hFFFF))
        retx_total_q <= retx_total_q + 16'd1;
      if (w_grant_evt && (ack_sent_total_q != 16'hFFFF))
        ack_sent_total_q <= ack_sent_total_q + 16'd1;
    end
  end

  assign retx_total_o     = retx_total_q;
  assign ack_sent_total_o = ack_sent_total_q;
`endif

endmodule
`default_nettype wire

// File: doc/laser_link_scheduler.md
Name: laser_link_scheduler

Overview:
- Sequences a single laser transmitter channel between two requesters: outgoing data frames and acknowledgements generated by the receive side.
- Buffers one frame of PKT_BYTES payload bytes and prefixes it with a sequence byte.
- Waits for a matching ACK from the receiver path, and retransmits on timeout up to MAX_RETRY times before flagging a link error.
- Sits between the host-side byte source, the laser transmitter (byte in, done pulse out) and the laser receiver (single-cycle byte-valid out).

Parameters:
- PKT_BYTES, 4: payload bytes per frame, 1..16.
- TIMEOUT_CYCLES, 4096: clock_base cycles in WAIT_ACK before a retransmit; fits 16 bits.
- MAX_RETRY, 3: retransmissions allowed per frame before ERROR.

Ports:
- clock_base  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-high.
- link_en  in  1  link enable; drives tx_en.
- src_valid  in  1  source byte valid.
- src_data  in  8  source byte.
- src_ready  out  1  block accepts src_data this cycle.
- tx_data  out  8  byte to transmitter; stable from the pulse until tx_done.
- tx_data_ready  out  1  single-cycle "load byte" pulse to transmitter.
- tx_en  out  1  transmitter enable.
- tx_done  in  1  transmitter finished the byte (1-cycle pulse).
- rx_valid  in  1  receiver produced a byte (1-cycle pulse).
- rx_byte  in  8  received byte.
- ack_req  in  1  receive side requests an ACK for ack_seq; held until granted.
- ack_seq  in  4  sequence number to acknowledge.
- ack_grant  out  1  1-cycle pulse when the ACK byte's tx_done arrives.
- seq_num  out  4  current frame sequence number.
- frame_sent  out  1  1-cycle pulse when a frame is acknowledged.
- link_err  out  1  sticky error flag.
- err_clear  in  1  clears link_err and returns ERROR to IDLE.

Behaviour:
- Reset values: src_ready=0, tx_data=0, tx_data_ready=0, ack_grant=0, frame_sent=0, link_err=0, seq_num=0. Buffer count=0, retry=0, timer=0, state=IDLE.
- tx_en is link_en combinationally.
- Byte encodings: header = {4'hA, seq_num}; ACK byte = {4'h5, seq}. An incoming ACK is rx_valid with rx_byte[7:4]==4'h5, carrying seq rx_byte[3:0].
- Transmit handshake, per byte:
  - pulse tx_data_ready for exactly one cycle with tx_data valid;
  - hold tx_data;
  - wait for tx_done;
  - the next pulse may occur the cycle after tx_done at the earliest.
- IDLE:
  - ack_req has priority → SEND_ACK.
  - Else if the buffer is full and link_en=1 → SEND_HDR.
  - Else if the buffer is not full → FILL.
- FILL:
  - src_ready=1 while count<PKT_BYTES.
  - On src_valid&&src_ready, write buf[count] and increment count.
  - When count reaches PKT_BYTES → IDLE.
  - ack_req seen in FILL → IDLE with no byte accepted that cycle.
- SEND_HDR: sends the header byte, then → SEND_DATA at index 0.
- SEND_DATA:
  - Sends buf[idx] in order; after the last tx_done → WAIT_ACK.
  - Timer is loaded to 0 on entry.
- WAIT_ACK: timer increments each cycle. Exits, highest priority first:
  1. Matching ACK (seq == seq_num) → frame_sent pulse, seq_num+1 mod 16, count=0, retry=0 → IDLE.
  2. ack_req → SEND_ACK; timer is frozen and WAIT_ACK resumes afterwards.
  3. timer == TIMEOUT_CYCLES-1:
     - if retry<MAX_RETRY → retry+1 → SEND_HDR (same seq, same buffer);
     - else → ERROR.
  - A non-matching ACK is ignored.
  - A matching ACK arriving during the SEND_ACK detour is latched and honoured on return.
- SEND_ACK:
  - Sends {4'h5, ack_seq}.
  - On tx_done, pulse ack_grant and return to the originating state (IDLE or WAIT_ACK).
- ERROR: link_err=1, no transmission, ack_req ignored. err_clear → IDLE with retry=0; the buffer is retained.
- link_en low in SEND_HDR, SEND_DATA or SEND_ACK:
  - abort at once to IDLE; ack_req stays pending.
  - A data frame is fully resent from the header on re-enable; retry is unchanged.
- reset mid-operation: everything returns to the reset values; buffered bytes are lost.

Optional Feature:
- Macro: LASER_LINK_STATS_EN.
- When defined, adds output retx_total[15:0] and output ack_sent_total[15:0]:
  - both are saturating counters, reset to 0, not cleared by err_clear;
  - retx_total increments on each timeout retransmit;
  - ack_sent_total increments on each ack_grant.
- When undefined, these ports and counters do not exist.

Decomposition:
- Package laser_link_pkg holds:
  - the state enum (IDLE, FILL, SEND_HDR, SEND_DATA, WAIT_ACK, SEND_ACK, ERROR);
  - HDR_TAG=4'hA and ACK_TAG=4'h5;
  - a function building the header and ACK bytes.
- Sub-module laser_frame_buffer: PKT_BYTES×8 register file with write index and count, and a read port by index.

Test Plan:
- Fill bytes 11,22,33,44 with seq 0 → tx_data sequence A0,11,22,33,44. Inject rx_byte 50 in WAIT_ACK → frame_sent pulse, seq_num=1.
- No ACK, TIMEOUT_CYCLES=64 → frame resent 3 times. After the 4th timeout, link_err=1. err_clear → IDLE, and the next frame is resent with header A0.
- ack_req with ack_seq=7 raised in WAIT_ACK → byte 57 sent, ack_grant pulses. Timer resumes without reset, and no ACK byte is interleaved mid-frame.
- rx_byte 53 while seq_num=0 → ignored, timeout retransmit follows. Then rx_byte 50 → accepted.
- link_en dropped during the 3rd payload byte → tx_en=0, state IDLE. Re-enable → the full frame restarts from A0, retry count is unchanged.
- Reset asserted in SEND_DATA → all outputs return to reset values on the same edge, seq_num=0.
